// File: rtl/pc_control.sv
// pc_control: program counter and control-flow resolution for the multi-cycle
// RV32I core. Issues fetch requests and resolves branch/JAL/JALR targets once
// the execute step reports completion.
module pc_control #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        fetch_req,
   input  logic        fetch_ack,
   input  logic        exec_done,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  funct3,
   input  logic        EQ,
   input  logic        LU,
   input  logic        LS,
   input  logic [31:0] imm,
   input  logic [31:0] alu_s,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        taken,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      WAIT_EXEC = 2'd2,
      HALT      = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        taken_q, taken_d;
   logic        mis_q, mis_d;

   logic        br_cond;
   logic        redirect;
   logic [31:0] target;

   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign taken      = taken_q;
   assign misaligned = mis_q;

   // State and architectural registers; reset wins over any in-flight update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         taken_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         taken_q <= taken_d;
         mis_q   <= mis_d;
      end
   end

   // Branch condition and next-PC target; jalr outranks jal outranks branch
   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         3'b000:  br_cond = EQ;
         3'b001:  br_cond = ~EQ;
         3'b100:  br_cond = LS;
         3'b101:  br_cond = ~LS;
         3'b110:  br_cond = LU;
         3'b111:  br_cond = ~LU;
         default: br_cond = 1'b0;
      endcase
      redirect = 1'b0;
      target   = pc_plus4;
      if (is_jalr) begin
         redirect = 1'b1;
         target   = {alu_s[31:1], 1'b0};
      end else if (is_jal) begin
         redirect = 1'b1;
         target   = pc_q + imm;
      end else if (is_branch && br_cond) begin
         redirect = 1'b1;
         target   = pc_q + imm;
      end
   end

   // Next-state logic; taken defaults low so it lives only for one FETCH cycle
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      taken_d = 1'b0;
      mis_d   = mis_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: if (fetch_ack) state_d = WAIT_EXEC;
         WAIT_EXEC: begin
            if (exec_done) begin
               if (target[1:0] != 2'b00) begin
                  // Illegal target: keep pc for the trap handler and stop
                  mis_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d    = target;
                  taken_d = redirect;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = HALT;
      endcase
   end

   // Moore output; suppressed while reset is held even if state is stale
   always_comb begin
      fetch_req = (state_q == FETCH) && !reset;
   end

endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: table-driven directed test of pc_control plus hand-written
// sequences for stalls, halting on a misaligned target and mid-flight reset.
module tb_pc_control;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req;
   logic        fetch_ack = 1'b0;
   logic        exec_done = 1'b0;
   logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic        EQ = 1'b0, LU = 1'b0, LS = 1'b0;
   logic [31:0] imm = 32'h0, alu_s = 32'h0;
   logic [31:0] pc, pc_plus4;
   logic        taken, misaligned;

   int checks = 0;
   int errors = 0;

   pc_control #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
      .exec_done(exec_done), .is_branch(is_branch), .is_jal(is_jal),
      .is_jalr(is_jalr), .funct3(funct3), .EQ(EQ), .LU(LU), .LS(LS),
      .imm(imm), .alu_s(alu_s), .pc(pc), .pc_plus4(pc_plus4),
      .taken(taken), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        br, jal, jalr;
      logic [2:0]  f3;
      logic        eq, lu, ls;
      logic [31:0] imm, alus;
      logic [31:0] epc;
      logic        etk;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input logic br, jal, jalr, input logic [2:0] f3,
                               input logic eq, lu, ls, input logic [31:0] im,
                               input logic [31:0] as, input logic [31:0] epc,
                               input logic etk);
      vec_t v;
      v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3;
      v.eq = eq; v.lu = lu; v.ls = ls; v.imm = im; v.alus = as;
      v.epc = epc; v.etk = etk;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clr_ctl();
      is_branch = 0; is_jal = 0; is_jalr = 0; funct3 = 0;
      EQ = 0; LU = 0; LS = 0; imm = 0; alu_s = 0;
   endtask

   // Wait (bounded) for FETCH, hand over one instruction, check the result
   task automatic apply(input vec_t v, input int idx);
      int n = 0;
      while (!fetch_req && n < 10) begin @(negedge clk); n++; end
      chk($sformatf("v%0d fetch_req_pre", idx), fetch_req, 1);
      fetch_ack = 1;
      @(negedge clk);
      fetch_ack = 0;
      is_branch = v.br; is_jal = v.jal; is_jalr = v.jalr; funct3 = v.f3;
      EQ = v.eq; LU = v.lu; LS = v.ls; imm = v.imm; alu_s = v.alus;
      exec_done = 1;
      @(negedge clk);
      exec_done = 0;
      clr_ctl();
      chk($sformatf("v%0d pc", idx), pc, v.epc);
      chk($sformatf("v%0d taken", idx), taken, v.etk);
      chk($sformatf("v%0d pc_plus4", idx), pc_plus4, v.epc + 32'd4);
      chk($sformatf("v%0d misaligned", idx), misaligned, 0);
      chk($sformatf("v%0d fetch_req", idx), fetch_req, 1);
   endtask

   initial begin
      //            br jal jalr f3     eq lu ls imm            alu_s         exp pc        tk
      tbl[0]  = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0004, 0);
      tbl[1]  = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0008, 0);
      tbl[2]  = mk(0, 1, 0, 3'b000, 0, 0, 0, 32'h8,         32'h0,        32'h0000_0010, 1);
      tbl[3]  = mk(1, 0, 0, 3'b000, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,        32'h0000_0008, 1);
      tbl[4]  = mk(0, 1, 0, 3'b000, 0, 0, 0, 32'h8,         32'h0,        32'h0000_0010, 1);
      tbl[5]  = mk(1, 0, 0, 3'b001, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,        32'h0000_0014, 0);
      tbl[6]  = mk(1, 0, 0, 3'b110, 0, 0, 1, 32'h100,       32'h0,        32'h0000_0018, 0);
      tbl[7]  = mk(1, 0, 0, 3'b100, 0, 0, 1, 32'h100,       32'h0,        32'h0000_0118, 1);
      tbl[8]  = mk(1, 0, 0, 3'b011, 1, 1, 1, 32'h100,       32'h0,        32'h0000_011C, 0);
      tbl[9]  = mk(1, 0, 0, 3'b101, 0, 0, 1, 32'h100,       32'h0,        32'h0000_0120, 0);
      tbl[10] = mk(1, 0, 0, 3'b111, 0, 0, 1, 32'h100,       32'h0,        32'h0000_0220, 1);
      tbl[11] = mk(1, 0, 0, 3'b010, 1, 1, 1, 32'h100,       32'h0,        32'h0000_0224, 0);
      // jalr outranks jal: imm ignored, low bit of alu_s cleared
      tbl[12] = mk(0, 1, 1, 3'b000, 0, 0, 0, 32'h40,        32'h105,      32'h0000_0104, 1);
      // jal outranks a not-taken branch
      tbl[13] = mk(1, 1, 0, 3'b000, 0, 0, 0, 32'h20,        32'h0,        32'h0000_0124, 1);
      tbl[14] = mk(0, 1, 0, 3'b000, 0, 0, 0, 32'hFFFF_FED8, 32'h0,        32'hFFFF_FFFC, 1);

      // Reset release
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst pc", pc, 0);
      chk("rst fetch_req", fetch_req, 0);
      chk("rst taken", taken, 0);
      chk("rst misaligned", misaligned, 0);
      reset = 0;
      #1;
      chk("idle fetch_req", fetch_req, 0);
      chk("idle pc", pc, 0);
      @(negedge clk);
      chk("first fetch_req", fetch_req, 1);

      for (int i = 0; i < 15; i++) apply(tbl[i], i);

      // Wrap: pc=FFFF_FFFC sequential step
      chk("wrap pc_plus4 pre", pc_plus4, 32'h0);
      apply(mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0), 15);
      chk("wrap pc_plus4 post", pc_plus4, 32'h4);

      // Redirect, then stall in FETCH with a stray exec_done
      apply(mk(0, 1, 0, 3'b000, 0, 0, 0, 32'h10, 32'h0, 32'h10, 1), 16);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin exec_done = 1; is_jal = 1; imm = 32'h40; end
         @(negedge clk);
         exec_done = 0;
         clr_ctl();
         chk($sformatf("stall%0d pc", c), pc, 32'h10);
         chk($sformatf("stall%0d fetch_req", c), fetch_req, 1);
         chk($sformatf("stall%0d taken", c), taken, 0);
      end
      apply(mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h14, 0), 17);

      // Misaligned JALR -> HALT
      fetch_ack = 1;
      @(negedge clk);
      fetch_ack = 0;
      is_jalr = 1; alu_s = 32'h106; exec_done = 1;
      @(negedge clk);
      exec_done = 0;
      clr_ctl();
      chk("mis pc", pc, 32'h14);
      chk("mis flag", misaligned, 1);
      chk("mis taken", taken, 0);
      chk("mis fetch_req", fetch_req, 0);
      fetch_ack = 1; exec_done = 1; is_jal = 1; imm = 32'h8;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("halt%0d pc", c), pc, 32'h14);
         chk($sformatf("halt%0d fetch_req", c), fetch_req, 0);
         chk($sformatf("halt%0d misaligned", c), misaligned, 1);
      end
      fetch_ack = 0; exec_done = 0;
      clr_ctl();

      // Reset out of HALT
      reset = 1;
      repeat (2) @(negedge clk);
      chk("unhalt pc", pc, 0);
      chk("unhalt misaligned", misaligned, 0);
      reset = 0;
      @(negedge clk);
      apply(mk(0, 1, 0, 3'b000, 0, 0, 0, 32'h40, 32'h0, 32'h40, 1), 18);

      // Reset in WAIT_EXEC together with exec_done
      fetch_ack = 1;
      @(negedge clk);
      fetch_ack = 0;
      is_jal = 1; imm = 32'h100; exec_done = 1; reset = 1;
      @(negedge clk);
      chk("midrst pc", pc, 0);
      chk("midrst taken", taken, 0);
      chk("midrst fetch_req", fetch_req, 0);
      exec_done = 0; reset = 0;
      clr_ctl();
      #1;
      chk("midrst idle fetch_req", fetch_req, 0);
      @(negedge clk);
      chk("midrst fetch_req", fetch_req, 1);
      chk("midrst pc2", pc, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter and control-flow unit for the multi-cycle RV32I core. It holds the architectural PC and requests instruction fetches with a req/ack handshake. After the execute step it samples the ALU comparator flags (EQ, LS, LU) and the ALU sum, then resolves branches, JAL and JALR into the next PC. It sits directly downstream of the ALU's comparator outputs and upstream of instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  out  1  PC is valid for instruction fetch (Moore, high only in FETCH).
- fetch_ack  in  1  instruction memory accepted the address; sampled only in FETCH.
- exec_done  in  1  execute results (flags, alu_s, decode bits) are stable this cycle; sampled only in WAIT_EXEC.
- is_branch, is_jal, is_jalr  in  1 each  decoded control-flow class of the current instruction.
- funct3  in  3  branch condition field.
- EQ, LU, LS  in  1 each  ALU equal, less-unsigned and less-signed flags. The ALU is driven with sub_sra=1 for branches.
- imm  in  32  sign-extended B/J immediate.
- alu_s  in  32  ALU sum output (rs1+imm for JALR).
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc+4 mod 2^32 (combinational), the link value for JAL/JALR.
- taken  out  1  one-cycle pulse when the PC was redirected.
- misaligned  out  1  sticky instruction-address-misaligned flag.

## Operation
- States: IDLE, FETCH, WAIT_EXEC, HALT.
- Reset (any state) forces the following on the next edge, including when reset lands mid-instruction:
  - state=IDLE, pc=RESET_PC, taken=0, misaligned=0.
  - fetch_req=0 while reset is high.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH: fetch_req=1. On fetch_ack -> WAIT_EXEC; otherwise hold. exec_done is ignored.
- WAIT_EXEC: on exec_done, compute the target:
  - Priority is is_jalr > is_jal > is_branch. With no control-flow bit set, target=pc+4.
  - JALR: target={alu_s[31:1],1'b0}.
  - JAL: target=pc+imm.
  - Branch taken: target=pc+imm. Branch not taken: target=pc+4.
  - Branch condition by funct3:
    - 000 EQ; 001 !EQ.
    - 100 LS; 101 !LS.
    - 110 LU; 111 !LU.
    - 010/011 are never taken.
  - All additions are 32-bit modulo 2^32; carry is discarded.
  - Flags and immediate are sampled only on the exec_done edge.
- Target legality:
  - If target[1:0]!=2'b00: pc is unchanged, misaligned<=1, taken stays 0, -> HALT.
  - Otherwise: pc<=target. taken<=1 if JAL, JALR or branch taken, else 0. -> FETCH.
- HALT: fetch_req=0, all inputs ignored, pc frozen. Left only via reset.
- fetch_ack outside FETCH and exec_done outside WAIT_EXEC have no effect.

## Timing
- Minimum instruction period is 2 cycles after the first fetch:
  - fetch_ack is accepted in the first FETCH cycle.
  - exec_done is accepted in the first WAIT_EXEC cycle.
- Reset sequence: reset deasserts at edge N, IDLE occupies cycle N, fetch_req=1 from cycle N+1.
- pc, state and taken update on the same edge that samples exec_done. The new pc is visible with fetch_req=1 in the following cycle.
- taken is high exactly one cycle: the first FETCH cycle after a redirect. It clears on the next edge regardless of fetch_ack.
- pc_plus4 follows pc combinationally. pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
- misaligned rises on the edge entering HALT and holds until reset.

## Test plan
- Reset release: hold reset 3 cycles, then release, with RESET_PC=0.
  - Required: pc=0 and fetch_req=0 during reset and the IDLE cycle, fetch_req=1 the next cycle.
  - With ack+done every opportunity and no control flow, pc sequences 0,4,8 at 2-cycle spacing and taken stays 0.
- Branch taken: pc=0x10, funct3=000, EQ=1, imm=-8 (0xFFFF_FFF8), exec_done.
  - Required: pc=0x08 and taken=1 for one cycle.
  - Same stimulus with funct3=001 gives pc=0x14 and taken=0.
- Unsigned/signed split: LU=0, LS=1.
  - funct3=110 -> pc+4.
  - funct3=100 -> pc+imm.
  - funct3=011 -> pc+4.
- JALR: alu_s=0x0000_0105.
  - Required: pc=0x104, taken=1.
  - alu_s=0x0000_0106 -> misaligned=1, pc unchanged, state HALT, fetch_req=0. Further acks and dones are ignored until reset.
- Handshake stall and priority:
  - Hold fetch_ack low for 5 FETCH cycles: required pc stable and fetch_req high throughout.
  - Pulse exec_done during FETCH: no effect.
  - Assert is_jal and is_branch together with imm=0x20: required pc+0x20 via JAL.
- Wrap and mid-operation reset:
  - pc=0xFFFF_FFFC, sequential instruction -> pc=0, pc_plus4=4.
  - Assert reset in WAIT_EXEC together with exec_done -> pc=RESET_PC, taken=0, state IDLE.
